bus_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the shared 32-bit datapath bus, which is driven by a 32:1 bus multiplexer.
- Accepts per-source bus requests, selects one owner at a time and drives the multiplexer's 5-bit select and enable.
- Inserts one dead turnaround cycle between owners.
- Sits between the control unit's source-request lines and the bus multiplexer.

---
 rtl/bus_arb_pkg.sv | 15 +
 rtl/rr_pick.sv | 34 +++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the round-robin bus arbiter.
// Optional statistics counters are enabled in bus_arbiter by defining BUS_ARB_STATS_EN.
package bus_arb_pkg;

   localparam int unsigned BUS_W   = 32;
   localparam int unsigned MAX_SRC = 32;
   localparam int unsigned SEL_W   = $clog2(MAX_SRC);

   typedef enum logic [1:0] {
      StIdle       = 2'd0,
      StGrant      = 2'd1,
      StTurnaround = 2'd2
   } state_e;

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set request at or above ptr_i, wrapping at NUM_SRC-1.
module rr_pick
   import bus_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC = 32,
   parameter int unsigned SEL_W   = 5
) (
   input  logic [NUM_SRC-1:0] req_i,
   input  logic [SEL_W-1:0]   ptr_i,
   output logic               valid_o,
   output logic [SEL_W-1:0]   index_o
);

   int unsigned       pos;
   logic [SEL_W-1:0]  idx;

   always_comb begin
      valid_o = 1'b0;
      index_o = '0;
      pos     = 0;
      idx     = '0;
      // Scan from the farthest offset down so the nearest request is assigned last and wins.
      for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
         pos = 32'(ptr_i) + unsigned'(i);
         if (pos >= NUM_SRC) pos = pos - NUM_SRC;
         idx = SEL_W'(pos);
         if (req_i[idx]) begin
            valid_o = 1'b1;
            index_o = idx;
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with one dead turnaround cycle between owners and MAX_HOLD pre-emption.
// Define BUS_ARB_STATS_EN to add saturating grant_count and contention_cycles outputs.
module bus_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned NUM_SRC  = 32,
   parameter int unsigned SEL_W    = 5,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic               clock,
   input  logic               reset_n,
   input  logic [NUM_SRC-1:0] req,
   input  logic               lock,
   output logic [NUM_SRC-1:0] grant,
   output logic [SEL_W-1:0]   bus_select,
   output logic               bus_enable,
   output logic               busy
`ifdef BUS_ARB_STATS_EN
   ,
   output logic [15:0]        grant_count,
   output logic [15:0]        contention_cycles
`endif
);

   state_e             state_q;
   logic [SEL_W-1:0]   ptr_q;
   logic [7:0]         hold_q;
   logic [NUM_SRC-1:0] grant_q;
   logic [SEL_W-1:0]   sel_q;
   logic               en_q;
   logic               busy_q;

   logic               pick_valid;
   logic [SEL_W-1:0]   pick_idx;
   logic [NUM_SRC-1:0] pick_onehot;
   logic               owner_req;
   logic               others;
   logic               hold_max;
   logic [SEL_W-1:0]   ptr_next;

   rr_pick #(
      .NUM_SRC (NUM_SRC),
      .SEL_W   (SEL_W)
   ) u_rr_pick (
      .req_i   (req),
      .ptr_i   (ptr_q),
      .valid_o (pick_valid),
      .index_o (pick_idx)
   );

   always_comb begin
      pick_onehot = NUM_SRC'(1) << pick_idx;
      owner_req   = req[sel_q];
      others      = |(req & ~grant_q);
      hold_max    = (hold_q == 8'(MAX_HOLD));
      ptr_next    = (sel_q == SEL_W'(NUM_SRC - 1)) ? '0 : sel_q + SEL_W'(1);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         ptr_q   <= '0;
         hold_q  <= '0;
         grant_q <= '0;
         sel_q   <= '0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle, StTurnaround: begin
               if (pick_valid) begin
                  state_q <= StGrant;
                  grant_q <= pick_onehot;
                  sel_q   <= pick_idx;
                  en_q    <= 1'b1;
                  hold_q  <= 8'd1;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= StIdle;
                  grant_q <= '0;
                  en_q    <= 1'b0;
                  busy_q  <= 1'b0;
               end
            end
            StGrant: begin
               if (!owner_req || (hold_max && !lock && others)) begin
                  state_q <= StTurnaround;
                  ptr_q   <= ptr_next;
                  grant_q <= '0;
                  en_q    <= 1'b0;
               end else if (hold_max) begin
                  // Locked owners saturate; an uncontended owner restarts its hold window.
                  if (!lock) hold_q <= 8'd1;
               end else begin
                  hold_q <= hold_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               grant_q <= '0;
               en_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign grant      = grant_q;
   assign bus_select = sel_q;
   assign bus_enable = en_q;
   assign busy       = busy_q;

`ifdef BUS_ARB_STATS_EN
   logic [15:0] grant_count_q;
   logic [15:0] contention_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         grant_count_q <= '0;
         contention_q  <= '0;
      end else begin
         if (state_q != StGrant && pick_valid && grant_count_q != 16'hffff) begin
            grant_count_q <= grant_count_q + 16'd1;
         end
         if (others && contention_q != 16'hffff) begin
            contention_q <= contention_q + 16'd1;
         end
      end
   end

   assign grant_count       = grant_count_q;
   assign contention_cycles = contention_q;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with hand-computed grant sequences.
module tb_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset_n;
   logic [31:0] req;
   logic        lock;
   logic [31:0] grant;
   logic [4:0]  bus_select;
   logic        bus_enable;
   logic        busy;
`ifdef BUS_ARB_STATS_EN
   logic [15:0] grant_count;
   logic [15:0] contention_cycles;
`endif

   int n_total = 0;
   int n_bad   = 0;

   bus_arbiter #(
      .NUM_SRC  (32),
      .SEL_W    (5),
      .MAX_HOLD (4)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .req        (req),
      .lock       (lock),
      .grant      (grant),
      .bus_select (bus_select),
      .bus_enable (bus_enable),
      .busy       (busy)
`ifdef BUS_ARB_STATS_EN
      ,
      .grant_count       (grant_count),
      .contention_cycles (contention_cycles)
`endif
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic exp_grant(input string tag, input int k);
      logic [31:0] oh;
      oh = 32'd1 << k;
      check({tag, ".grant"}, grant, oh);
      check({tag, ".sel"}, 32'(bus_select), 32'(k));
      check({tag, ".en"}, 32'(bus_enable), 32'd1);
      check({tag, ".busy"}, 32'(busy), 32'd1);
   endtask

   task automatic exp_gap(input string tag, input int sel);
      check({tag, ".grant"}, grant, 32'd0);
      check({tag, ".sel"}, 32'(bus_select), 32'(sel));
      check({tag, ".en"}, 32'(bus_enable), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd1);
   endtask

   task automatic exp_idle(input string tag);
      check({tag, ".grant"}, grant, 32'd0);
      check({tag, ".en"}, 32'(bus_enable), 32'd0);
      check({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      req     = '1;
      lock    = 1'b0;
      step();
      step();
      step();
      exp_idle("rst");
      check("rst.sel", 32'(bus_select), 32'd0);

      // Release reset with everyone requesting: ptr=0 picks source 0.
      reset_n = 1'b1;
      step();
      exp_grant("rst_rel", 0);
      req = '0;
      step();
      exp_gap("rst_rel_ta", 0);
      step();
      exp_idle("rst_rel_idle");

      // Single requester: no turnaround while uncontended (hold reloads).
      req = 32'd1 << 5;
      for (int i = 0; i < 10; i++) begin
         step();
         exp_grant("single", 5);
      end
      req = '0;
      step();
      exp_gap("single_ta", 5);
      step();
      exp_idle("single_idle");

      // Pre-emption: ptr=6 so 7 wins first, then 3, then 7 again.
      req = (32'd1 << 3) | (32'd1 << 7);
      for (int i = 0; i < 4; i++) begin
         step();
         exp_grant("pre_a", 7);
      end
      step();
      exp_gap("pre_ta1", 7);
      for (int i = 0; i < 4; i++) begin
         step();
         exp_grant("pre_b", 3);
      end
      step();
      exp_gap("pre_ta2", 3);
      step();
      exp_grant("pre_c", 7);
      req = '0;
      step();
      exp_gap("pre_ta3", 7);
      step();
      exp_idle("pre_idle");

      // Wrap-around: release 30 leaves ptr=31, so 31 precedes 0.
      req = 32'd1 << 30;
      step();
      exp_grant("wrap30", 30);
      req = (32'd1 << 31) | 32'd1;
      step();
      exp_gap("wrap_ta1", 30);
      step();
      exp_grant("wrap31", 31);
      req = 32'd1;
      step();
      exp_gap("wrap_ta2", 31);
      step();
      exp_grant("wrap0", 0);
      req = '0;
      step();
      exp_gap("wrap_ta3", 0);
      step();
      exp_idle("wrap_idle");

      // Lock: ptr=1, owner 2 keeps the bus for 12 cycles despite req[9].
      req  = (32'd1 << 2) | (32'd1 << 9);
      lock = 1'b1;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_grant("lock", 2);
      end
      lock = 1'b0;
      step();
      exp_gap("lock_ta", 2);
      step();
      exp_grant("lock9", 9);

      // Async reset mid-grant, then restart from ptr=0 (5 wins; old ptr would give 20).
      req = 32'd1 << 12;
      step();
      exp_gap("ar_ta", 9);
      step();
      exp_grant("ar12", 12);
      #3;
      reset_n = 1'b0;
      #1;
      exp_idle("ar_async");
      check("ar_async.sel", 32'(bus_select), 32'd0);
      req = (32'd1 << 5) | (32'd1 << 20);
      #1;
      reset_n = 1'b1;
      step();
      exp_grant("ar_restart", 5);
      req = '0;
      step();
      exp_gap("ar_ta2", 5);
      step();
      exp_idle("ar_idle");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
